// File: rtl/clock_set_ctrl_pkg.sv
// Purpose : shared types, digit indices and digit limits for the time-setting controller.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
package clock_set_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    EDIT  = 2'd1,
    APPLY = 2'd2
  } set_state_t;

  // Digit index inside the packed {h10,h1,m10,m1,s10,s1} word.
  localparam logic [2:0] DIG_H10 = 3'd5;
  localparam logic [2:0] DIG_H1  = 3'd4;
  localparam logic [2:0] DIG_M10 = 3'd3;
  localparam logic [2:0] DIG_M1  = 3'd2;
  localparam logic [2:0] DIG_S10 = 3'd1;
  localparam logic [2:0] DIG_S1  = 3'd0;

  localparam logic [3:0] MAX_H10   = 4'd2;
  localparam logic [3:0] MAX_H1_LO = 4'd3;
  localparam logic [3:0] MAX_TENS  = 4'd5;
  localparam logic [3:0] MAX_UNITS = 4'd9;

  // Largest legal value of the digit at index sel; hours-units depend on hours-tens.
  function automatic logic [3:0] digit_max(input logic [2:0] sel, input logic [3:0] h10);
    logic [3:0] m;
    case (sel)
      DIG_H10:          m = MAX_H10;
      DIG_H1:           m = (h10 == MAX_H10) ? MAX_H1_LO : MAX_UNITS;
      DIG_M10, DIG_S10: m = MAX_TENS;
      default:          m = MAX_UNITS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Purpose : bundles the button inputs, live time and the set/run controls of clock_set_ctrl.
// Latency : n/a (wiring only).
// Backpr. : none; slave = controller side, master = environment / counter-chain side.
interface clock_set_ctrl_if;
  logic        btn_mode;     // raw MODE button, asynchronous
  logic        btn_inc;      // raw INC button, asynchronous
  logic [23:0] cur_time;     // live digits {h10,h1,m10,m1,s10,s1}
  logic        run_en;       // counters may count
  logic        edit_active;  // controller is in EDIT
  logic [2:0]  edit_sel;     // cursor digit index, 0 outside EDIT
  logic [5:0]  set;          // per-digit load strobe
  logic [23:0] set_value;    // shadow digits for the counters' load inputs

  modport slave (
    input  btn_mode, btn_inc, cur_time,
    output run_en, edit_active, edit_sel, set, set_value
  );

  modport master (
    output btn_mode, btn_inc, cur_time,
    input  run_en, edit_active, edit_sel, set, set_value
  );
endinterface

// File: rtl/clock_set_ctrl_debounce.sv
// Purpose : synchronise and debounce one push-button; one-cycle pulse per accepted press.
// Latency : 2 sync cycles + DEB_CYCLES stable samples from raw edge to press_p.
// Backpr. : none; holding never repeats, release gives no pulse.
// Ports   : clk, reset (async active-low), btn_raw (async), press_p (1-cycle pulse).
module btn_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_p
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Polarity is folded in before the synchroniser so every flop holds "pressed = 1"
  // and a cleared synchroniser reads as released.
  logic sync1_q, sync2_q;
  logic lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic btn_act;

  assign btn_act = ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_act;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts consecutive samples that disagree with the accepted level; the
  // DEB_CYCLES-th such sample flips the level.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_p = sync2_q & ~lvl_q & (cnt_q == CNT_LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// Purpose : time-setting controller: cursor walk over HH:MM:SS, shadow edit, one-cycle commit.
// Latency : press pulse -> state/shadow update on the next clk edge; APPLY lasts one cycle.
// Backpr. : none; run_en holds the counter chain off while editing/applying.
// Ports   : clk, reset (async active-low), bus (slave modport: buttons, cur_time in;
//           run_en, edit_active, edit_sel, set, set_value out).
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int DEB_CYCLES     = 50000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  clock_set_ctrl_if.slave  bus
);

  logic mode_p, inc_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_deb_mode (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_mode),
    .press_p (mode_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_deb_inc (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_inc),
    .press_p (inc_p)
  );

  set_state_t       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [5:0][3:0]  shadow_q, shadow_d;
  logic [3:0]       dig_cur, dig_max, dig_inc;

  // Cursor digit and its incremented value; anything at or above the limit
  // (including out-of-range captured digits) wraps to 0.
  assign dig_cur = shadow_q[sel_q];
  assign dig_max = digit_max(sel_q, shadow_q[DIG_H10]);
  assign dig_inc = (dig_cur >= dig_max) ? 4'd0 : dig_cur + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      sel_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    case (state_q)
      RUN: begin
        if (mode_p) begin
          shadow_d = bus.cur_time;
          sel_d    = DIG_H10;
          state_d  = EDIT;
        end
      end
      EDIT: begin
        // MODE has priority: a coincident INC pulse is dropped.
        if (mode_p) begin
          if (sel_q == DIG_S1) begin
            state_d = APPLY;
          end else begin
            sel_d = sel_q - 3'd1;
          end
        end else if (inc_p) begin
          shadow_d[sel_q] = dig_inc;
          // Stepping into the 20s must not leave an illegal 24..29 hour.
          if ((sel_q == DIG_H10) && (dig_inc == MAX_H10) &&
              (shadow_q[DIG_H1] > MAX_H1_LO)) begin
            shadow_d[DIG_H1] = 4'd0;
          end
        end
      end
      APPLY: begin
        state_d = RUN;
        sel_d   = '0;
      end
      default: begin
        state_d = RUN;
        sel_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.run_en      = (state_q == RUN);
    bus.edit_active = (state_q == EDIT);
    bus.edit_sel    = (state_q == EDIT) ? sel_q : 3'd0;
    bus.set         = (state_q == APPLY) ? 6'b111111 : 6'b000000;
    bus.set_value   = shadow_q;
  end

endmodule
